// File: rtl/apb_reg_slave.sv
// APB register slave: CTRL/SCRATCH/IRQ regs, ID and transfer counter; pready after WAIT_STATES extra access cycles.
// Backpressure is pready only; any cycle of psel=0 during an access abandons the transfer without side effects.
module apb_reg_slave #(
  parameter int AW_APB      = 32,
  parameter int DW_APB      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  apb_clk,
  input  logic                  sys_areset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [AW_APB-1:0]     paddr,
  input  logic [DW_APB-1:0]     pwdata,
  input  logic [DW_APB/8-1:0]   pstrb,
  output logic [DW_APB-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [DW_APB-1:0]     irq_src,
  output logic [DW_APB-1:0]     ctrl,
  output logic                  irq
);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_SCR    = 8'h04;
  localparam logic [7:0] OFF_STAT   = 8'h08;
  localparam logic [7:0] OFF_MASK   = 8'h0C;
  localparam logic [7:0] OFF_ID     = 8'h10;
  localparam logic [7:0] OFF_CNT    = 8'h14;
  localparam logic [DW_APB-1:0] ID_VAL  = 'hA9B0_0001;
  localparam logic [DW_APB-1:0] CNT_ONE = 'h1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_wait_cnt, w_wait_cnt_nxt;
  logic [DW_APB-1:0]   r_ctrl, r_scratch, r_irq_status, r_irq_mask, r_xfer_cnt;
  logic                r_irq;

  logic [7:0]          w_off;
  logic [DW_APB-1:0]   w_rd_val;
  logic                w_err;
  logic                w_ok;
  logic                w_wr;
  logic [DW_APB-1:0]   w_wmask;
  logic [DW_APB-1:0]   w_w1c;
  logic                w_unused_paddr;

  // Only the low address byte decodes; upper bits alias the map.
  assign w_off          = paddr[7:0];
  assign w_unused_paddr = ^paddr;

  always_ff @(posedge apb_clk or posedge sys_areset) begin
    if (sys_areset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    pready         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (psel && !penable) begin
          w_state_nxt    = S_ACCESS;
          w_wait_cnt_nxt = 3'(WAIT_STATES);
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          w_state_nxt = S_IDLE;
        end else if (penable) begin
          if (r_wait_cnt == 3'd0) begin
            pready      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt - 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Misaligned offsets fall into the default arm, so they error like unmapped ones.
  always_comb begin
    w_rd_val = '0;
    w_err    = 1'b0;
    case (w_off)
      OFF_CTRL: w_rd_val = r_ctrl;
      OFF_SCR:  w_rd_val = r_scratch;
      OFF_STAT: w_rd_val = r_irq_status;
      OFF_MASK: w_rd_val = r_irq_mask;
      OFF_ID: begin
        w_rd_val = ID_VAL;
        w_err    = pwrite;
      end
      OFF_CNT: begin
        w_rd_val = r_xfer_cnt;
        w_err    = pwrite;
      end
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < DW_APB/8; b++) begin
      w_wmask[b*8 +: 8] = {8{pstrb[b]}};
    end
  end

  assign w_ok    = pready && !w_err;
  assign w_wr    = w_ok && pwrite;
  assign w_w1c   = (w_wr && (w_off == OFF_STAT)) ? (pwdata & w_wmask) : '0;
  assign pslverr = pready && w_err;
  assign prdata  = (w_ok && !pwrite) ? w_rd_val : '0;

  always_ff @(posedge apb_clk or posedge sys_areset) begin
    if (sys_areset) begin
      r_ctrl       <= '0;
      r_scratch    <= '0;
      r_irq_status <= '0;
      r_irq_mask   <= '0;
      r_xfer_cnt   <= '0;
      r_irq        <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_CTRL)) r_ctrl     <= (r_ctrl & ~w_wmask) | (pwdata & w_wmask);
      if (w_wr && (w_off == OFF_SCR))  r_scratch  <= (r_scratch & ~w_wmask) | (pwdata & w_wmask);
      if (w_wr && (w_off == OFF_MASK)) r_irq_mask <= (r_irq_mask & ~w_wmask) | (pwdata & w_wmask);
      // New events override a same-cycle clear so no pulse is lost.
      r_irq_status <= (r_irq_status & ~w_w1c) | irq_src;
      if (w_ok) r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
      r_irq <= |(r_irq_status & r_irq_mask);
    end
  end

  assign ctrl = r_ctrl;
  assign irq  = r_irq;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench: two slaves (0 and 1 wait states) on a shared bus; a reference model predicts each
// completion and a negedge monitor scores data, error flag and access latency.
module tb_apb_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] irq_src0, irq_src1;
  int          dsel;

  logic        psel0, psel1;
  logic [31:0] prdata0, prdata1, ctrl0, ctrl1;
  logic        pready0, pready1, pslverr0, pslverr1, irq0, irq1;
  logic [31:0] prdata_m;
  logic        pready_m, pslverr_m;

  always #5 clk = ~clk;

  assign psel0     = psel && (dsel == 0);
  assign psel1     = psel && (dsel == 1);
  assign pready_m  = (dsel == 1) ? pready1  : pready0;
  assign pslverr_m = (dsel == 1) ? pslverr1 : pslverr0;
  assign prdata_m  = (dsel == 1) ? prdata1  : prdata0;

  apb_reg_slave #(.AW_APB(32), .DW_APB(32), .WAIT_STATES(0)) u_dut0 (
    .apb_clk(clk), .sys_areset(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .irq_src(irq_src0), .ctrl(ctrl0), .irq(irq0)
  );

  apb_reg_slave #(.AW_APB(32), .DW_APB(32), .WAIT_STATES(1)) u_dut1 (
    .apb_clk(clk), .sys_areset(rst), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .irq_src(irq_src1), .ctrl(ctrl1), .irq(irq1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] m_ctrl[2], m_scr[2], m_stat[2], m_mask[2], m_cnt[2];
  logic [7:0]  offs [0:11] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                               8'h18, 8'h20, 8'hFC, 8'h02, 8'h05, 8'h0E};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ctrl[d] = '0; m_scr[d] = '0; m_stat[d] = '0; m_mask[d] = '0; m_cnt[d] = '0;
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    return (old & ~lanes(s)) | (nw & lanes(s));
  endfunction

  task automatic model_xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] data,
                            input logic [3:0] s, output logic [31:0] rd, output logic err);
    logic [7:0]  off;
    logic [31:0] val;
    bit          mapped;
    off    = a[7:0];
    val    = '0;
    mapped = 1'b1;
    rd     = '0;
    case (off)
      8'h00:   val = m_ctrl[d];
      8'h04:   val = m_scr[d];
      8'h08:   val = m_stat[d];
      8'h0C:   val = m_mask[d];
      8'h10:   val = 32'hA9B0_0001;
      8'h14:   val = m_cnt[d];
      default: mapped = 1'b0;
    endcase
    err = !mapped || (a[1:0] != 2'b00) || (wr && (off == 8'h10 || off == 8'h14));
    if (!err) begin
      if (wr) begin
        case (off)
          8'h00:   m_ctrl[d] = merge(m_ctrl[d], data, s);
          8'h04:   m_scr[d]  = merge(m_scr[d], data, s);
          8'h08:   m_stat[d] = m_stat[d] & ~(data & lanes(s));
          8'h0C:   m_mask[d] = merge(m_mask[d], data, s);
          default: ;
        endcase
      end else begin
        rd = val;
      end
      m_cnt[d] = m_cnt[d] + 32'd1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the completion cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] data,
                      input logic [3:0] s);
    exp_t        e;
    logic [31:0] rd;
    logic        err;
    int          n;
    model_xfer(d, wr, a, data, s, rd, err);
    e.rdata = rd;
    e.err   = err;
    e.lat   = d + 1;
    sb_q.push_back(e);
    dsel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = data; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready_m && n < 16);
    chk("xfer_pready_seen", {31'd0, pready_m}, 32'd1);
    if (!pready_m && sb_q.size() > 0) void'(sb_q.pop_front());
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_ctrl0"}, ctrl0, m_ctrl[0]);
    chk({tag, "_ctrl1"}, ctrl1, m_ctrl[1]);
    chk({tag, "_irq0"}, {31'd0, irq0}, {31'd0, |(m_stat[0] & m_mask[0])});
    chk({tag, "_irq1"}, {31'd0, irq1}, {31'd0, |(m_stat[1] & m_mask[1])});
  endtask

  // Monitor: counts access cycles and scores every completion against the queue head.
  initial begin : monitor
    exp_t e;
    int   acc;
    acc = 0;
    forever begin
      @(negedge clk);
      if (psel && penable) acc++;
      else acc = 0;
      if (pready_m) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pready: got pready=1 expected no completion at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("rdata", prdata_m, e.rdata);
          chk("pslverr", {31'd0, pslverr_m}, {31'd0, e.err});
          chk("latency", acc, e.lat);
        end
      end else begin
        chk("idle_prdata", prdata_m, 32'd0);
        chk("idle_pslverr", {31'd0, pslverr_m}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    int          d, idx;
    bit          wr;
    logic [31:0] a;
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    irq_src0 = '0; irq_src1 = '0; dsel = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl1", ctrl1, 32'd0);
    chk("rst_ctrl0", ctrl0, 32'd0);
    chk("rst_irq1", {31'd0, irq1}, 32'd0);
    chk("rst_pready1", {31'd0, pready1}, 32'd0);
    chk("rst_pslverr1", {31'd0, pslverr1}, 32'd0);
    chk("rst_prdata1", prdata1, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Byte-lane write to CTRL, then counter readback
    xfer(1, 1'b1, 32'h0000_0000, 32'h0000_00FF, 4'b0001);
    chk("ctrl_after_write", ctrl1, 32'h0000_00FF);
    xfer(1, 1'b0, 32'h0000_0014, 32'h0, 4'h0);

    // ID is read-only, counter ignores errored transfers
    xfer(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    xfer(1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF);
    xfer(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    xfer(1, 1'b0, 32'h0000_0014, 32'h0, 4'h0);

    // Unmapped, misaligned, and upper-address aliasing
    xfer(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    xfer(1, 1'b0, 32'h0000_0002, 32'h0, 4'h0);
    xfer(1, 1'b1, 32'hABCD_0104, 32'h0BAD_F00D, 4'b1010);
    xfer(1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);

    // Abort by dropping psel mid-access: no commit, no count
    dsel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h5555_5555; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_ctrl", ctrl1, m_ctrl[1]);
    xfer(1, 1'b0, 32'h0000_0014, 32'h0, 4'h0);

    // Interrupt set, mask, registered irq, and set-beats-clear
    xfer(1, 1'b1, 32'h0000_000C, 32'h0000_0001, 4'hF);
    irq_src1 = 32'h1;
    @(posedge clk); #1;
    irq_src1 = 32'h0;
    m_stat[1] = m_stat[1] | 32'h1;
    chk("irq_not_yet", {31'd0, irq1}, 32'd0);
    @(posedge clk); #1;
    chk("irq_raised", {31'd0, irq1}, {31'd0, |(m_stat[1] & m_mask[1])});
    xfer(1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
    irq_src1 = 32'h1;
    xfer(1, 1'b1, 32'h0000_0008, 32'h0000_0001, 4'hF);
    irq_src1 = 32'h0;
    m_stat[1] = m_stat[1] | 32'h1;
    xfer(1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
    xfer(1, 1'b1, 32'h0000_0008, 32'h0000_0001, 4'b0001);
    @(posedge clk); #1;
    chk("irq_cleared", {31'd0, irq1}, {31'd0, |(m_stat[1] & m_mask[1])});

    // Zero-wait slave, back-to-back writes then readback
    xfer(0, 1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF);
    xfer(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    xfer(0, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      d   = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 11));
      a   = ($urandom() & 32'hFFFF_FF00) | {24'h0, offs[idx]};
      xfer(d, wr, a, $urandom(), 4'($urandom_range(0, 15)));
      @(posedge clk); #1;
      chk_outputs("rand");
    end

    // Reset during the access phase of a CTRL write
    dsel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_mid_pready", {31'd0, pready1}, 32'd0);
    chk("rst_mid_ctrl", ctrl1, 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ctrl", ctrl1, 32'd0);
    xfer(1, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF);
    chk("post_rst_write", ctrl1, 32'hCAFE_F00D);
    xfer(1, 1'b0, 32'h0000_0014, 32'h0, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
